trace_capture_unit: RTL

- Parametrised on-board trace recorder for the CPU debug top level.
- Samples CHANNELS probe buses of DATA_W bits into a circular buffer of DEPTH entries and holds a programmable pre-trigger history.
- Freezes once the post-trigger window is full; the stored window is then read back oldest-first.
- Replaces a fixed-width vendor probe with a self-contained, re-targetable capture block clocked from the CPU clock.

---
 rtl/trace_capture_pkg.sv | 19 +
 rtl/trace_capture_ram.sv | 37 +++
 rtl/trace_capture_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the trace capture unit.
package trace_capture_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int TS_W = 16;

  // Width of a selector over n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module trace_capture_ram
  import trace_capture_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port with output register that holds between reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Trace recorder: pre-trigger history, trigger compare, post window, oldest-first readout.
// Optional per-sample 16-bit timestamps when TRACE_CAPTURE_TIMESTAMP_EN is defined.
module trace_capture_unit
  import trace_capture_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_W-1:0]     probe,
  input  logic                           sample_en,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [sel_width(CHANNELS)-1:0] trig_ch,
  input  logic [DATA_W-1:0]              trig_mask,
  input  logic [DATA_W-1:0]              trig_value,
  output logic [2:0]                     state,
  output logic                           done,
  output logic [AW-1:0]                  trig_pos,
  input  logic [AW-1:0]                  rd_addr,
  input  logic                           rd_en,
  output logic [CHANNELS*DATA_W-1:0]     rd_data,
  output logic                           rd_valid,
  output logic [TS_W-1:0]                rd_ts
);

  localparam int PW     = CHANNELS * DATA_W;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam logic [AW-1:0] ONE_AW   = AW'(1);
  localparam logic [AW-1:0] PRE_LAST = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] PRE_OFF  = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_LD  = AW'(POST_N);

  state_t            state_r, state_nxt;
  logic [AW-1:0]     wp_r, fill_r, post_r, trig_pos_r;
  logic              done_r, rd_valid_r;
  logic [DATA_W-1:0] sel_ch_s;
  logic              hit_s, wr_s, start_s, trig_s, re_s;
  logic [AW-1:0]     raddr_s;

  // Trigger channel select; out-of-range selectors fall back to channel 0.
  always_comb begin
    sel_ch_s = probe[DATA_W-1:0];
    for (int k = 1; k < CHANNELS; k++) begin
      sel_ch_s = (int'(trig_ch) == k) ? probe[k*DATA_W +: DATA_W] : sel_ch_s;
    end
  end

  assign hit_s = sample_en && ((sel_ch_s & trig_mask) == (trig_value & trig_mask));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic; abort outranks everything.
  always_comb begin
    state_nxt = state_r;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt = arm ? PRETRIG : IDLE;
        PRETRIG: state_nxt = (sample_en && (fill_r == PRE_LAST)) ? ARMED : PRETRIG;
        ARMED: begin
          if (hit_s) begin
            state_nxt = (POST_N == 0) ? DONE : POST;
          end else begin
            state_nxt = ARMED;
          end
        end
        POST:    state_nxt = (sample_en && (post_r == ONE_AW)) ? DONE : POST;
        DONE:    state_nxt = arm ? PRETRIG : DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: write strobe, capture start and trigger capture.
  always_comb begin
    wr_s    = 1'b0;
    start_s = 1'b0;
    trig_s  = 1'b0;
    case (state_r)
      IDLE, DONE: start_s = arm && !abort;
      PRETRIG, POST: wr_s = sample_en && !abort;
      ARMED: begin
        wr_s   = sample_en && !abort;
        trig_s = hit_s && !abort;
      end
      default: begin
        wr_s    = 1'b0;
        start_s = 1'b0;
        trig_s  = 1'b0;
      end
    endcase
  end

  // Pointers, pre-trigger fill, post-trigger countdown and status.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_r       <= '0;
      fill_r     <= '0;
      post_r     <= '0;
      trig_pos_r <= '0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      if (start_s) begin
        wp_r   <= '0;
        fill_r <= '0;
      end else if (wr_s) begin
        wp_r   <= wp_r + ONE_AW;
        fill_r <= (state_r == PRETRIG) ? fill_r + ONE_AW : fill_r;
      end
      if (trig_s) begin
        trig_pos_r <= wp_r;
        post_r     <= POST_LD;
      end else if (wr_s && (state_r == POST)) begin
        post_r <= post_r - ONE_AW;
      end
      done_r     <= (state_nxt == DONE);
      rd_valid_r <= re_s;
    end
  end

  assign re_s    = rd_en && (state_r == DONE);
  assign raddr_s = trig_pos_r - PRE_OFF + rd_addr;

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  localparam int RW = PW + TS_W;
  logic [TS_W-1:0] ts_r;

  // Free-running cycle counter stamped into every stored sample.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  logic [RW-1:0] wdata_s, rdata_s;
  assign wdata_s = {ts_r, probe};
  assign rd_data = rdata_s[PW-1:0];
  assign rd_ts   = rdata_s[RW-1 -: TS_W];
`else
  localparam int RW = PW;
  logic [RW-1:0] wdata_s, rdata_s;
  assign wdata_s = probe;
  assign rd_data = rdata_s;
  assign rd_ts   = TS_W'(0);
`endif

  trace_capture_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (wr_s && reset),
    .waddr (wp_r),
    .wdata (wdata_s),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  assign state    = state_r;
  assign done     = done_r;
  assign trig_pos = trig_pos_r;
  assign rd_valid = rd_valid_r;

endmodule
